// File: rtl/mulpop_arbiter_pkg.sv
// ============================================================================
// Module      : mulpop_pkg
// Description : Shared types, widths and the popcount helper for mulpop_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mulpop_pkg;

    localparam int A_W    = 24;
    localparam int W_W    = 32;
    localparam int PROD_W = 48;
    localparam int ONES_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_POP  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic [ONES_W-1:0] popcount32(input logic [31:0] v);
        logic [ONES_W-1:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + ONES_W'(v[i]);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mulpop_arbiter_if.sv
// ============================================================================
// Module      : mulpop_arbiter_if
// Description : Requester-side bus of the multiply/popcount arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mulpop_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int A_W   = 24,
    parameter int W_W   = 32
) ();
    logic [N_REQ-1:0]     req;
    logic [N_REQ*A_W-1:0] a1;
    logic [N_REQ*A_W-1:0] a2;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     done;
    logic [W_W-1:0]       result_w;
    logic [5:0]           result_ones;
    logic                 result_valid;
    logic                 busy;
    logic [15:0]          op_count;

    modport master (
        output req, a1, a2,
        input  grant, done, result_w, result_ones, result_valid, busy, op_count
    );

    modport slave (
        input  req, a1, a2,
        output grant, done, result_w, result_ones, result_valid, busy, op_count
    );
endinterface

`default_nettype wire

// File: rtl/mulpop_arbiter_engine.sv
// ============================================================================
// Module      : mulpop_engine
// Description : Sequential 24x24 shift-add multiplier with popcount/fits stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mulpop_engine
    import mulpop_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              n_reset,
    input  wire logic              start_i,
    input  wire logic              step_i,
    input  wire logic              pop_i,
    input  wire logic [A_W-1:0]    a1_i,
    input  wire logic [A_W-1:0]    a2_i,
    output logic                   last_o,
    output logic [W_W-1:0]         word_o,
    output logic [ONES_W-1:0]      ones_o,
    output logic                   valid_o
);
    localparam int CNT_W = $clog2(A_W);

    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] mcand_q;
    logic [A_W-1:0]    mplier_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ONES_W-1:0] ones_q;
    logic              valid_q;

    // Multiplicand shifts left and multiplier shifts right, so each step only
    // inspects mplier_q[0] for the current bit.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{(PROD_W-A_W){1'b0}}, a1_i};
            mplier_q <= a2_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ones_q  <= '0;
            valid_q <= 1'b0;
        end else if (pop_i) begin
            ones_q  <= popcount32(acc_q[W_W-1:0]);
            valid_q <= (acc_q[PROD_W-1:W_W] == '0);
        end
    end

    assign last_o  = (cnt_q == CNT_W'(A_W-1));
    assign word_o  = acc_q[W_W-1:0];
    assign ones_o  = ones_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/mulpop_arbiter.sv
// ============================================================================
// Module      : mulpop_arbiter
// Description : Round-robin scheduler sharing one multiply/popcount engine.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mulpop_arbiter #(
    parameter int N_REQ = 4,
    parameter int A_W   = 24,
    parameter int W_W   = 32
) (
    input  wire logic      clk,
    input  wire logic      n_reset,
    mulpop_arbiter_if.slave bus
);
    import mulpop_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [W_W-1:0]     result_w_q;
    logic [ONES_W-1:0]  result_ones_q;
    logic               result_valid_q;
    logic [15:0]        op_count_q;

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               eng_start, eng_step, eng_pop, resp_load;
    logic               eng_last, eng_valid;
    logic [W_W-1:0]     eng_word;
    logic [ONES_W-1:0]  eng_ones;

    function automatic logic [PTR_W-1:0] add_wrap(input logic [PTR_W-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return PTR_W'(s);
    endfunction

    // Scan from the farthest candidate down so the one nearest ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req[add_wrap(ptr_q, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = add_wrap(ptr_q, i);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_valid) state_d = ST_MULT;
            ST_MULT: if (eng_last)   state_d = ST_POP;
            ST_POP:                  state_d = ST_RESP;
            ST_RESP:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_start = (state_q == ST_IDLE) && pick_valid;
        eng_step  = (state_q == ST_MULT);
        eng_pop   = (state_q == ST_POP);
        resp_load = (state_q == ST_RESP);
        grant_d   = eng_start ? (N_REQ'(1) << pick_idx) : '0;
        done_d    = resp_load ? (N_REQ'(1) << owner_q)  : '0;
        ptr_d     = add_wrap(pick_idx, 1);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ptr_q          <= '0;
            owner_q        <= '0;
            grant_q        <= '0;
            done_q         <= '0;
            result_w_q     <= '0;
            result_ones_q  <= '0;
            result_valid_q <= 1'b0;
            op_count_q     <= '0;
        end else begin
            grant_q <= grant_d;
            done_q  <= done_d;
            if (eng_start) begin
                owner_q <= pick_idx;
                ptr_q   <= ptr_d;
            end
            if (resp_load) begin
                result_w_q     <= eng_word;
                result_ones_q  <= eng_ones;
                result_valid_q <= eng_valid;
                op_count_q     <= op_count_q + 16'd1;
            end
        end
    end

    mulpop_engine u_engine (
        .clk     (clk),
        .n_reset (n_reset),
        .start_i (eng_start),
        .step_i  (eng_step),
        .pop_i   (eng_pop),
        .a1_i    (bus.a1[int'(pick_idx)*A_W +: A_W]),
        .a2_i    (bus.a2[int'(pick_idx)*A_W +: A_W]),
        .last_o  (eng_last),
        .word_o  (eng_word),
        .ones_o  (eng_ones),
        .valid_o (eng_valid)
    );

    assign bus.grant        = grant_q;
    assign bus.done         = done_q;
    assign bus.result_w     = result_w_q;
    assign bus.result_ones  = result_ones_q;
    assign bus.result_valid = result_valid_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.op_count     = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mulpop_arbiter.sv
// ============================================================================
// Module      : tb_mulpop_arbiter
// Description : Self-checking bench: vector table, corner sequences, random run.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mulpop_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    mulpop_arbiter_if #(.N_REQ(N), .A_W(24), .W_W(32)) bus ();

    mulpop_arbiter #(.N_REQ(N), .A_W(24), .W_W(32)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles left in the current operation (0 = free).
    int          m_left, m_ptr, m_owner;
    logic [47:0] m_prod;
    logic [3:0]  m_grant, m_done;
    logic [31:0] m_w;
    logic [5:0]  m_ones;
    logic        m_valid;
    logic [15:0] m_cnt;

    typedef struct {
        logic [23:0] a1;
        logic [23:0] a2;
        logic [31:0] w;
        logic [5:0]  ones;
        logic        valid;
    } vec_t;
    vec_t tbl[7];

    int gq[$], gt[$], dq[$], dt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_ops(input int k, input logic [23:0] x, input logic [23:0] y);
        bus.a1[k*24 +: 24] = x;
        bus.a2[k*24 +: 24] = y;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        tick();
    endtask

    task automatic wait_pulse(input bit is_done, input int budget, output int cycles, output logic [3:0] val);
        cycles = 0;
        val    = '0;
        repeat (budget) begin
            tick();
            cycles++;
            if ((is_done ? bus.done : bus.grant) != 4'b0) begin
                val = is_done ? bus.done : bus.grant;
                return;
            end
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_ptr = 0; m_owner = 0; m_prod = '0;
        m_grant = '0; m_done = '0; m_w = '0; m_ones = '0; m_valid = 1'b0; m_cnt = '0;
    endtask

    task automatic model_edge(input logic [3:0] rq, input logic [95:0] a1v, input logic [95:0] a2v);
        m_grant = '0;
        m_done  = '0;
        if (m_left == 0) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (rq[k] && m_grant == 4'b0) begin
                    m_grant[k] = 1'b1;
                    m_owner    = k;
                    m_ptr      = (k + 1) % N;
                    m_prod     = 48'(a1v[k*24 +: 24]) * 48'(a2v[k*24 +: 24]);
                    m_left     = 26;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_done[m_owner] = 1'b1;
                m_w     = m_prod[31:0];
                m_ones  = 6'($countones(m_prod[31:0]));
                m_valid = (m_prod[47:32] == 16'd0);
                m_cnt   = m_cnt + 16'd1;
            end
        end
    endtask

    function automatic logic [63:0] outs_dut();
        return {bus.grant, bus.done, bus.busy, bus.result_valid, bus.result_ones, bus.result_w, bus.op_count};
    endfunction

    initial begin
        int          cyc, bad, ov;
        logic [3:0]  v;
        logic [3:0]  rq;
        logic [95:0] a1v, a2v;

        tbl[0] = '{24'd3,       24'd5,       32'h0000000F, 6'd4,  1'b1};
        tbl[1] = '{24'hFFFFFF,  24'hFFFFFF,  32'hFE000001, 6'd8,  1'b0};
        tbl[2] = '{24'd0,       24'h123456,  32'h00000000, 6'd0,  1'b1};
        tbl[3] = '{24'd1,       24'h800000,  32'h00800000, 6'd1,  1'b1};
        tbl[4] = '{24'h010000,  24'h010000,  32'h00000000, 6'd0,  1'b0};
        tbl[5] = '{24'hFFFFFF,  24'd1,       32'h00FFFFFF, 6'd24, 1'b1};
        tbl[6] = '{24'h00FFFF,  24'h010001,  32'hFFFFFFFF, 6'd32, 1'b1};

        n_reset = 1'b0;
        bus.req = '0;
        bus.a1  = '0;
        bus.a2  = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset outputs", outs_dut(), 64'd0);
        n_reset = 1'b1;
        tick();

        // Vector table through requester 0; operands scrambled after grant.
        for (int i = 0; i < 7; i++) begin
            set_ops(0, tbl[i].a1, tbl[i].a2);
            bus.req = 4'b0001;
            wait_pulse(1'b0, 40, cyc, v);
            chk($sformatf("vec%0d grant", i), 64'(v), 64'(4'b0001));
            bus.req = '0;
            set_ops(0, 24'hA5A5A5, 24'h5A5A5A);
            wait_pulse(1'b1, 40, cyc, v);
            chk($sformatf("vec%0d latency", i), 64'(cyc), 64'd26);
            chk($sformatf("vec%0d done", i), 64'(v), 64'(4'b0001));
            chk($sformatf("vec%0d result", i),
                {25'd0, bus.result_ones, bus.result_valid, bus.result_w},
                {25'd0, tbl[i].ones, tbl[i].valid, tbl[i].w});
            chk($sformatf("vec%0d op_count", i), 64'(bus.op_count), 64'(i + 1));
            chk($sformatf("vec%0d busy", i), 64'(bus.busy), 64'd0);
        end

        // All four requesters held: round-robin order and 27-cycle spacing.
        do_reset();
        for (int k = 0; k < N; k++) set_ops(k, 24'(k + 1), 24'd7);
        bus.req = 4'b1111;
        ov = 0;
        for (int t = 1; t <= 130; t++) begin
            tick();
            if (bus.grant != 4'b0) begin gq.push_back(idx_of(bus.grant)); gt.push_back(t); end
            if (bus.done  != 4'b0) begin dq.push_back(idx_of(bus.done));  dt.push_back(t); end
            if ((bus.grant != 4'b0 && bus.done != 4'b0) ||
                $countones(bus.grant) > 1 || $countones(bus.done) > 1) ov++;
        end
        bus.req = '0;
        chk("rr pulse overlap", 64'(ov), 64'd0);
        chk("rr grant count", 64'(gq.size()), 64'd5);
        chk("rr done count", 64'(dq.size()), 64'd4);
        if (gq.size() == 5 && dq.size() == 4) begin
            for (int g = 0; g < 5; g++) begin
                chk($sformatf("rr grant%0d idx", g), 64'(gq[g]), 64'(g % N));
                if (g > 0) chk($sformatf("rr grant%0d gap", g), 64'(gt[g] - gt[g-1]), 64'd27);
            end
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("rr done%0d idx", d), 64'(dq[d]), 64'(d));
                chk($sformatf("rr done%0d time", d), 64'(dt[d] - gt[d]), 64'd26);
            end
        end

        // Late request by 2, cancelled request by 1.
        do_reset();
        bus.req = 4'b0011;
        wait_pulse(1'b0, 40, cyc, v);
        chk("cancel first grant", 64'(v), 64'(4'b0001));
        bus.req = 4'b0010;
        repeat (5) tick();
        bus.req = 4'b0100;
        bad = 0;
        v   = '0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (bus.grant[1] || bus.done[1]) bad++;
            if (v == 4'b0 && bus.grant != 4'b0) v = bus.grant;
        end
        bus.req = '0;
        chk("cancel next grant", 64'(v), 64'(4'b0100));
        chk("cancel req1 untouched", 64'(bad), 64'd0);

        // Reset mid-MULT discards the op and the pointer.
        do_reset();
        set_ops(2, 24'd3, 24'd5);
        bus.req = 4'b0100;
        wait_pulse(1'b0, 40, cyc, v);
        bus.req = '0;
        wait_pulse(1'b1, 40, cyc, v);
        chk("midrst pre result", {bus.op_count, bus.result_w}, {16'd1, 32'h0000000F});
        bus.req = 4'b0100;
        wait_pulse(1'b0, 40, cyc, v);
        chk("midrst second grant", 64'(v), 64'(4'b0100));
        bus.req = 4'b1010;
        repeat (9) tick();
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("midrst outputs", outs_dut(), 64'd0);
        bad = 0;
        repeat (2) begin
            tick();
            if (bus.done != 4'b0 || bus.busy) bad++;
        end
        chk("midrst held", 64'(bad), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        wait_pulse(1'b0, 40, cyc, v);
        chk("midrst ptr restart", 64'(v), 64'(4'b0010));
        bus.req = '0;
        wait_pulse(1'b1, 40, cyc, v);
        chk("midrst restart done", 64'(v), 64'(4'b0010));

        // op_count wrap from 0xFFFF.
        do_reset();
        @(negedge clk);
        dut.op_count_q = 16'hFFFF;
        #1;
        chk("wrap preset", 64'(bus.op_count), 64'h0000_FFFF);
        set_ops(0, 24'd3, 24'd5);
        bus.req = 4'b0001;
        wait_pulse(1'b0, 40, cyc, v);
        bus.req = '0;
        wait_pulse(1'b1, 40, cyc, v);
        chk("wrap done", 64'(v), 64'(4'b0001));
        chk("wrap op_count", 64'(bus.op_count), 64'd0);

        // Random traffic against the reference model, compared every cycle.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            bus.a1 = {$urandom(), $urandom(), $urandom()};
            bus.a2 = {$urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) bus.a1 = '1;
            rq  = bus.req;
            a1v = bus.a1;
            a2v = bus.a2;
            tick();
            model_edge(rq, a1v, a2v);
            chk($sformatf("random cycle %0d", c), outs_dut(),
                {m_grant, m_done, (m_left != 0), m_valid, m_ones, m_w, m_cnt});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
